// File: rtl/codec_test_sequencer.sv
// Purpose: drives LFSR test words plus error-injection masks into a codec and scores its decoded output.
// Latency: one vector issued per cycle; each result scored LATENCY cycles after issue; done LATENCY+1 cycles after last issue.
// Backpressure: none; the codec is assumed fixed-latency, and start is ignored while a run is in progress.
module codec_test_sequencer #(
  parameter int          LATENCY = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_vectors,
  input  logic [1:0]  flip_mode,
  output logic [15:0] codec_data_in,
  output logic [23:0] codec_bit_flip,
  input  logic [15:0] codec_data_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [15:0] nv_q;
  logic [15:0] cnt;
  logic [15:0] data_hold;
  logic [1:0]  mode_q;
  logic [4:0]  pos;
  logic [4:0]  pos_inc;
  logic [23:0] mask;
  logic        accept;
  logic        issue;

  logic [15:0]        exp_dat [LATENCY];
  logic [LATENCY-1:0] exp_vld;

  assign pos_inc = (pos == 5'd23) ? 5'd0 : pos + 5'd1;

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_vectors != 16'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (cnt == nv_q - 16'd1) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt == 16'(LATENCY - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Injection mask for the current position; modes 0 and 3 inject nothing.
  always_comb begin
    mask = 24'd0;
    case (mode_q)
      2'd1:    mask = 24'd1 << pos;
      2'd2:    mask = (24'd1 << pos) | (24'd1 << pos_inc);
      default: mask = 24'd0;
    endcase
  end

  assign codec_bit_flip = issue ? mask : 24'd0;
  assign codec_data_in  = issue ? lfsr : data_hold;
  assign busy           = (state == RUN) || (state == DRAIN);
  assign done           = (state == DONE);

  // State register plus the per-state cycle counter (restarts on every state change).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept || state_nxt != state) cnt <= 16'd0;
      else                              cnt <= cnt + 16'd1;
    end
  end

  // Run configuration, LFSR word generator and mask position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      pos       <= 5'd0;
      nv_q      <= 16'd0;
      mode_q    <= 2'd0;
      data_hold <= 16'd0;
    end else if (accept) begin
      lfsr   <= SEED;
      pos    <= 5'd0;
      nv_q   <= num_vectors;
      mode_q <= flip_mode;
    end else if (issue) begin
      data_hold <= lfsr;
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pos       <= pos_inc;
    end
  end

  // Expected-word delay line matching the codec pipeline depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_vld <= '0;
      for (int i = 0; i < LATENCY; i++) exp_dat[i] <= 16'd0;
    end else begin
      exp_vld[0] <= issue;
      exp_dat[0] <= lfsr;
      for (int i = 1; i < LATENCY; i++) begin
        exp_vld[i] <= exp_vld[i-1];
        exp_dat[i] <= exp_dat[i-1];
      end
    end
  end

  // Score the word leaving the delay line; counts saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count <= 16'd0;
      fail_count <= 16'd0;
    end else if (accept) begin
      pass_count <= 16'd0;
      fail_count <= 16'd0;
    end else if (exp_vld[LATENCY-1]) begin
      if (exp_dat[LATENCY-1] == codec_data_out) begin
        if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
      end else begin
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/codec_test_sequencer.md
CODEC_TEST_SEQUENCER -- requirements
Module: codec_test_sequencer

Interface
REQ-001 Parameter LATENCY, default 2: codec pipeline depth in clk cycles, from codec_data_in/codec_bit_flip to codec_data_out; legal range 1..8.
REQ-002 Parameter SEED, default 16'hACE1: LFSR load value; SHALL be nonzero.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle request to begin a run.
REQ-006 Port num_vectors, input, 16: vectors per run; sampled on an accepted start.
REQ-007 Port flip_mode, input, 2: 0 none, 1 single-bit, 2 double-bit, 3 treated as 0; sampled on an accepted start.
REQ-008 Port codec_data_in, output, 16: data word driven to the codec.
REQ-009 Port codec_bit_flip, output, 24: error-injection mask driven to the codec.
REQ-010 Port codec_data_out, input, 16: decoded word returned by the codec.
REQ-011 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-012 Port done, output, 1: one-cycle pulse at run end.
REQ-013 Port pass_count, output, 16: compared vectors that matched.
REQ-014 Port fail_count, output, 16: compared vectors that mismatched.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-016 Transition IDLE->RUN: start=1 and num_vectors!=0. On the same edge, load the LFSR with SEED, clear both counts, clear position pos, and latch num_vectors and flip_mode.
REQ-017 Transition IDLE->DONE: start=1 and num_vectors==0. Counts are cleared and no vector is issued.
REQ-018 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-019 Issue rule: RUN issues exactly one vector per cycle, for the latched number of cycles, then goes to DRAIN.
REQ-020 Issued word: codec_data_in = current LFSR state.
- LFSR advances after each issue: shift left, bit0 = d[15]^d[13]^d[12]^d[10].
REQ-021 Injection mask for each issued vector:
- mode 1: only bit pos set.
- mode 2: bits pos and (pos+1) mod 24 set.
- mode 0: all zero.
- pos increments mod 24 after each issue (23 wraps to 0).
REQ-022 codec_bit_flip SHALL be 0 in every non-issue cycle. codec_data_in holds its last value outside issue cycles.
REQ-023 Expected-data tracking: each issued word enters a LATENCY-deep expected pipeline with a valid bit.
- When a valid entry reaches the tail, compare it with codec_data_out in that cycle.
- Match increments pass_count; mismatch increments fail_count.
- Both counts saturate at 16'hFFFF.
REQ-024 DRAIN lasts exactly LATENCY cycles after the last issue, so the final vector is compared. It then goes to DONE.
REQ-025 DONE lasts one cycle with done=1, then returns to IDLE. pass_count and fail_count hold until the next accepted start.
REQ-026 Invariant: pass_count + fail_count == latched num_vectors at done (absent saturation).

Reset
REQ-027 rst_n low, including mid-run, SHALL immediately force all of the following:
- state IDLE
- busy=0, done=0
- codec_data_in=0, codec_bit_flip=0
- pass_count=0, fail_count=0
- LFSR=SEED, pos=0
- all expected-pipeline valid bits cleared
REQ-028 After rst_n deasserts, the first start is accepted on the first clk edge.

Verification
REQ-029 Ideal codec model (LATENCY=2, corrects single errors), start with num_vectors=100 and flip_mode=1 -> busy for 102 cycles (100 issue + 2 drain), then done pulse; pass_count=100, fail_count=0; issued masks cycle 24'h000001, 24'h000002, ... 24'h800000, then back to 24'h000001.
REQ-030 flip_mode=0, num_vectors=5 -> all five codec_bit_flip values are 0; first codec_data_in=16'hACE1, second=16'h59C3; pass_count=5.
REQ-031 Codec model with output bit 0 stuck high, num_vectors=4 -> fail_count equals the number of issued words with bit0=0; pass_count+fail_count=4.
REQ-032 start with num_vectors=0 -> DONE the next cycle, done pulses once, no nonzero codec_bit_flip, both counts 0.
REQ-033 rst_n asserted for one cycle during RUN at vector 10 -> all outputs 0 immediately. A new start with num_vectors=3 then issues 16'hACE1 first and ends with pass_count=3.
REQ-034 start pulsed repeatedly during RUN and DRAIN -> ignored: exactly one done pulse, and counts reflect only the original num_vectors.
